// File: rtl/pipe_skid_reg.sv
// Pipeline register between two stages. It uses a valid/ready handshake with a two-entry skid buffer,
// so in_ready comes straight from a flop. It also provides flush-to-NOP, an occupancy output and a saturating stall counter.
module pipe_skid_reg #(
   parameter int unsigned          DATA_W   = 128,
   parameter int unsigned          PC_W     = 30,
   parameter logic [DATA_W-1:0]    NOP_DATA = '0,
   parameter int unsigned          CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_en_,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_en_,
   output logic [PC_W-1:0]   out_pc,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt,
   input  logic              cnt_clr
);

   logic              head_v_q, head_v_d;
   logic [PC_W-1:0]   head_pc_q, head_pc_d;
   logic [DATA_W-1:0] head_data_q, head_data_d;
   logic              skid_v_q, skid_v_d;
   logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              in_ready_q, in_ready_d;
   logic [1:0]        occ_q, occ_d;
   logic [CNT_W-1:0]  stall_q, stall_d;
   logic              acc, pop;

   assign acc = ~in_en_ & in_ready_q;
   assign pop = head_v_q & out_ready;

   always_comb begin
      head_v_d    = head_v_q;
      head_pc_d   = head_pc_q;
      head_data_d = head_data_q;
      skid_v_d    = skid_v_q;
      skid_pc_d   = skid_pc_q;
      skid_data_d = skid_data_q;
      if (flush) begin
         head_v_d    = 1'b0;
         head_pc_d   = '0;
         head_data_d = NOP_DATA;
         skid_v_d    = 1'b0;
         skid_pc_d   = '0;
         skid_data_d = NOP_DATA;
      end else if (!head_v_q) begin
         if (acc) begin
            head_v_d    = 1'b1;
            head_pc_d   = in_pc;
            head_data_d = in_data;
         end
      end else if (pop) begin
         if (skid_v_q) begin
            head_pc_d   = skid_pc_q;
            head_data_d = skid_data_q;
            if (acc) begin
               skid_pc_d   = in_pc;
               skid_data_d = in_data;
            end else begin
               skid_v_d = 1'b0;
            end
         end else if (acc) begin
            head_pc_d   = in_pc;
            head_data_d = in_data;
         end else begin
            // Draining to empty: the payload reverts to NOP and the PC keeps its last value.
            head_v_d    = 1'b0;
            head_data_d = NOP_DATA;
         end
      end else if (acc) begin
         skid_v_d    = 1'b1;
         skid_pc_d   = in_pc;
         skid_data_d = in_data;
      end
      in_ready_d = ~skid_v_d;
      occ_d      = {1'b0, head_v_d} + {1'b0, skid_v_d};
   end

   always_comb begin
      stall_d = stall_q;
      if (cnt_clr)
         stall_d = '0;
      else if (head_v_q && !out_ready && stall_q != '1)
         stall_d = stall_q + 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head_v_q    <= 1'b0;
         head_pc_q   <= '0;
         head_data_q <= NOP_DATA;
         skid_v_q    <= 1'b0;
         skid_pc_q   <= '0;
         skid_data_q <= NOP_DATA;
         in_ready_q  <= 1'b1;
         occ_q       <= '0;
         stall_q     <= '0;
      end else begin
         head_v_q    <= head_v_d;
         head_pc_q   <= head_pc_d;
         head_data_q <= head_data_d;
         skid_v_q    <= skid_v_d;
         skid_pc_q   <= skid_pc_d;
         skid_data_q <= skid_data_d;
         in_ready_q  <= in_ready_d;
         occ_q       <= occ_d;
         stall_q     <= stall_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_en_   = ~head_v_q;
   assign out_pc    = head_pc_q;
   assign out_data  = head_data_q;
   assign occupancy = occ_q;
   assign stall_cnt = stall_q;

endmodule
